// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, stalling on req/ack memories and counting retirements.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        mem_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [3:0]  alu_ctrl,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [31:0] instret
);
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_LD, S_BRANCH
    } state_t;

    typedef enum logic [3:0] {
        OP_ILL, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B
    } op_t;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    op_t         op;
    logic [3:0]  rtype_alu;
    logic        retire;
    logic        unused_instr;

    // Only the opcode field matters here; the rest feeds the datapath.
    assign unused_instr = ^instr[20:0];

    always_comb begin
        op = OP_ILL;
        casez (instr[31:21])
            OPC_ADD:        op = OP_ADD;
            OPC_SUB:        op = OP_SUB;
            OPC_AND:        op = OP_AND;
            OPC_ORR:        op = OP_ORR;
            OPC_LDUR:       op = OP_LDUR;
            OPC_STUR:       op = OP_STUR;
            11'b10110100???: op = OP_CBZ;
            11'b000101?????: op = OP_B;
            default:        op = OP_ILL;
        endcase
    end

    always_comb begin
        rtype_alu = ALU_ADD;
        case (op)
            OP_SUB:  rtype_alu = ALU_SUB;
            OP_AND:  rtype_alu = ALU_AND;
            OP_ORR:  rtype_alu = ALU_ORR;
            default: rtype_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR: state_d = S_EXEC_R;
                    OP_LDUR, OP_STUR:               state_d = S_ADDR;
                    OP_CBZ, OP_B:                   state_d = S_BRANCH;
                    default:                        state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_ADDR:   state_d = (op == OP_STUR) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (dmem_ack) state_d = S_WB_LD;
            S_MEM_WR: if (dmem_ack) state_d = S_FETCH;
            S_WB_LD:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // A store retires on its ack cycle; everything else on its final writeback/branch cycle.
    assign retire = (state_q == S_WB_R) || (state_q == S_WB_LD) || (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WR) && dmem_ack);
    assign instret_d = instret_q + 32'(retire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_AND;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
                pc_write = imem_ack;
            end
            S_DECODE: illegal = (op == OP_ILL);
            S_EXEC_R: alu_ctrl = rtype_alu;
            S_WB_R: begin
                alu_ctrl  = rtype_alu;
                reg_write = 1'b1;
            end
            S_ADDR: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_ADD;
                reg2loc  = (op == OP_STUR);
            end
            S_MEM_RD: begin
                dmem_req = 1'b1;
                alu_src  = 1'b1;
                alu_ctrl = ALU_ADD;
            end
            S_MEM_WR: begin
                dmem_req  = 1'b1;
                mem_write = 1'b1;
                reg2loc   = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = ALU_ADD;
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                pc_src = 1'b1;
                if (op == OP_CBZ) begin
                    reg2loc  = 1'b1;
                    alu_ctrl = ALU_PASSB;
                    pc_write = zero;
                end else begin
                    pc_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle schedules built from the
// instruction-class timing rules, with randomized waits, stray acks and zero flag.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic       imem_req, dmem_req, mem_write, pc_write, pc_src, ir_write, reg2loc, alu_src;
        logic [3:0] alu_ctrl;
        logic       reg_write, mem_to_reg, illegal;
    } ctl_t;

    typedef struct {
        logic ia;
        logic da;
        logic z;
        ctl_t exp;
        logic ret;
    } cyc_t;

    typedef enum int {C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL} cls_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, mem_write, pc_write, pc_src, ir_write, reg2loc, alu_src;
    logic [3:0]  alu_ctrl;
    logic        reg_write, mem_to_reg, illegal;
    logic [31:0] instret;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] cnt = 32'h0;
    cyc_t        sch[$];
    ctl_t        obs_q[$];
    logic [31:0] robs[$];
    logic [31:0] rexp[$];
    ctl_t        outs;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg2loc(reg2loc),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    assign outs = {imem_req, dmem_req, mem_write, pc_write, pc_src, ir_write, reg2loc, alu_src,
                   alu_ctrl, reg_write, mem_to_reg, illegal};

    function automatic logic rb();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic logic [3:0] alu_of(cls_t c);
        case (c)
            C_SUB:   return 4'b0110;
            C_AND:   return 4'b0000;
            C_ORR:   return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [31:0] mk_instr(cls_t c);
        logic [31:0] r;
        r = $urandom;
        case (c)
            C_ADD:  return {11'h458, r[20:0]};
            C_SUB:  return {11'h658, r[20:0]};
            C_AND:  return {11'h450, r[20:0]};
            C_ORR:  return {11'h550, r[20:0]};
            C_LDUR: return {11'h7C2, r[20:0]};
            C_STUR: return {11'h7C0, r[20:0]};
            C_CBZ:  return {8'hB4, r[23:0]};
            C_B:    return {6'b000101, r[25:0]};
            default: begin
                case (r[31:30])
                    2'd0:    return 32'h0000_0000;
                    2'd1:    return 32'hFFFF_FFFF;
                    2'd2:    return {11'h488, r[20:0]};
                    default: return {11'h7C1, r[20:0]};
                endcase
            end
        endcase
    endfunction

    task automatic push(input logic ia, input logic da, input logic z, input ctl_t e, input logic ret);
        cyc_t c;
        c.ia = ia; c.da = da; c.z = z; c.exp = e; c.ret = ret;
        sch.push_back(c);
    endtask

    // Expected per-cycle schedule for one instruction: iw/dw are wait cycles before each ack.
    task automatic build(input cls_t c, input int iw, input int dw, input logic z);
        ctl_t e;
        sch.delete();
        e = '0; e.imem_req = 1'b1;
        for (int k = 0; k < iw; k++) push(1'b0, rb(), rb(), e, 1'b0);
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b1, rb(), rb(), e, 1'b0);
        e = '0; e.illegal = (c == C_ILL);
        push(rb(), rb(), rb(), e, 1'b0);
        e = '0;
        case (c)
            C_ADD, C_SUB, C_AND, C_ORR: begin
                e.alu_ctrl = alu_of(c);
                push(rb(), rb(), rb(), e, 1'b0);
                e.reg_write = 1'b1;
                push(rb(), rb(), rb(), e, 1'b1);
            end
            C_LDUR: begin
                e.alu_src = 1'b1; e.alu_ctrl = 4'b0010;
                push(rb(), rb(), rb(), e, 1'b0);
                e.dmem_req = 1'b1;
                for (int k = 0; k < dw; k++) push(rb(), 1'b0, rb(), e, 1'b0);
                push(rb(), 1'b1, rb(), e, 1'b0);
                e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                push(rb(), rb(), rb(), e, 1'b1);
            end
            C_STUR: begin
                e.alu_src = 1'b1; e.alu_ctrl = 4'b0010; e.reg2loc = 1'b1;
                push(rb(), rb(), rb(), e, 1'b0);
                e.dmem_req = 1'b1; e.mem_write = 1'b1;
                for (int k = 0; k < dw; k++) push(rb(), 1'b0, rb(), e, 1'b0);
                push(rb(), 1'b1, rb(), e, 1'b1);
            end
            C_CBZ: begin
                e.pc_src = 1'b1; e.reg2loc = 1'b1; e.alu_ctrl = 4'b0111; e.pc_write = z;
                push(rb(), rb(), z, e, 1'b1);
            end
            C_B: begin
                e.pc_src = 1'b1; e.pc_write = 1'b1;
                push(rb(), rb(), rb(), e, 1'b1);
            end
            default: ;
        endcase
    endtask

    // Plays the schedule; optionally backdoors the counter to all-ones at cycle force_at.
    task automatic run_seq(input logic [31:0] ins, input int max, input int force_at);
        obs_q.delete(); robs.delete(); rexp.delete();
        for (int i = 0; i < sch.size() && i < max; i++) begin
            @(negedge clk);
            instr = ins; imem_ack = sch[i].ia; dmem_ack = sch[i].da; zero = sch[i].z;
            if (i == force_at) force dut.instret_q = 32'hFFFF_FFFF;
            #1;
            if (i == force_at) begin
                release dut.instret_q;
                cnt = 32'hFFFF_FFFF;
            end
            obs_q.push_back(outs); robs.push_back(instret); rexp.push_back(cnt);
            @(posedge clk);
            if (sch[i].ret) cnt = cnt + 32'd1;
        end
    endtask

    task automatic test_reset();
        ctl_t e;
        reset = 1'b0; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests++;
            if (outs !== '0 || instret !== 32'h0) begin
                failed++; $display("FAIL reset_hold ctl got %h want 0, instret got %h want 0", outs, instret);
            end
        end
        @(negedge clk); reset = 1'b1; #1;
        tests++;
        if (outs !== '0) begin failed++; $display("FAIL reset_idle ctl got %h want 0", outs); end
        @(posedge clk); #1;
        e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        tests++;
        if (outs !== e) begin failed++; $display("FAIL reset_first_fetch ctl got %h want %h", outs, e); end
        #1 imem_ack = 1'b0;
        cnt = 32'h0;
    endtask

    task automatic test_add();
        build(C_ADD, 0, 0, 1'b0);
        run_seq(32'h8B02_0020, 99, -1);
        foreach (obs_q[i]) begin
            tests++;
            if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL add ctl cyc%0d got %h want %h", i, obs_q[i], sch[i].exp); end
            tests++;
            if (robs[i] !== rexp[i]) begin failed++; $display("FAIL add instret cyc%0d got %h want %h", i, robs[i], rexp[i]); end
        end
    endtask

    task automatic test_ldur_wait();
        build(C_LDUR, 0, 2, 1'b0);
        run_seq(32'hF840_8020, 99, -1);
        tests++;
        if (obs_q.size() != 7) begin failed++; $display("FAIL ldur_len got %0d want 7", obs_q.size()); end
        foreach (obs_q[i]) begin
            tests++;
            if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL ldur ctl cyc%0d got %h want %h", i, obs_q[i], sch[i].exp); end
            tests++;
            if (robs[i] !== rexp[i]) begin failed++; $display("FAIL ldur instret cyc%0d got %h want %h", i, robs[i], rexp[i]); end
        end
    endtask

    task automatic test_stur_cbz();
        cls_t        cl[3] = '{C_STUR, C_CBZ, C_CBZ};
        logic [31:0] ins[3] = '{32'hF800_0020, 32'hB400_0040, 32'hB400_0040};
        logic        zz[3] = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            build(cl[t], 1, 1, zz[t]);
            run_seq(ins[t], 99, -1);
            foreach (obs_q[i]) begin
                tests++;
                if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL stur_cbz%0d ctl cyc%0d got %h want %h", t, i, obs_q[i], sch[i].exp); end
                tests++;
                if (robs[i] !== rexp[i]) begin failed++; $display("FAIL stur_cbz%0d instret cyc%0d got %h want %h", t, i, robs[i], rexp[i]); end
            end
        end
    endtask

    task automatic test_illegal();
        build(C_ILL, 0, 0, 1'b0);
        run_seq(32'h0000_0000, 99, -1);
        build(C_B, 0, 0, 1'b0);
        run_seq(32'h1400_0001, 1, -1);
        foreach (obs_q[i]) begin
            tests++;
            if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL illegal_next_fetch ctl got %h want %h", obs_q[i], sch[i].exp); end
            tests++;
            if (robs[i] !== rexp[i]) begin failed++; $display("FAIL illegal instret got %h want %h", robs[i], rexp[i]); end
        end
        // the B whose fetch was just consumed still has to finish
        sch.delete(); begin ctl_t e; e = '0; push(rb(), rb(), rb(), e, 1'b0); e.pc_src = 1'b1; e.pc_write = 1'b1; push(rb(), rb(), rb(), e, 1'b1); end
        run_seq(32'h1400_0001, 99, -1);
        foreach (obs_q[i]) begin
            tests++;
            if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL illegal_then_b ctl cyc%0d got %h want %h", i, obs_q[i], sch[i].exp); end
        end
    endtask

    task automatic test_random();
        cls_t        c;
        logic [31:0] ins;
        for (int n = 0; n < 150; n++) begin
            c = cls_t'($urandom_range(8, 0));
            ins = mk_instr(c);
            build(c, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rb());
            run_seq(ins, 99, -1);
            foreach (obs_q[i]) begin
                tests++;
                if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL rand%0d ins %h ctl cyc%0d got %h want %h", n, ins, i, obs_q[i], sch[i].exp); end
                tests++;
                if (robs[i] !== rexp[i]) begin failed++; $display("FAIL rand%0d instret cyc%0d got %h want %h", n, i, robs[i], rexp[i]); end
            end
        end
    endtask

    task automatic test_midop_reset();
        build(C_LDUR, 1, 6, 1'b0);
        run_seq(32'hF840_8020, 6, -1);
        foreach (obs_q[i]) begin
            tests++;
            if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL midop ctl cyc%0d got %h want %h", i, obs_q[i], sch[i].exp); end
        end
        #1;
        tests++;
        if (dmem_req !== 1'b1 || instret !== cnt) begin
            failed++; $display("FAIL midop_pre dmem_req got %b want 1, instret got %h want %h", dmem_req, instret, cnt);
        end
        reset = 1'b0; #1;
        cnt = 32'h0;
        tests++;
        if (outs !== '0 || instret !== cnt) begin
            failed++; $display("FAIL midop_abort ctl got %h want 0, instret got %h want 0", outs, instret);
        end
        repeat (2) @(negedge clk);
        @(negedge clk); reset = 1'b1; #1;
        tests++;
        if (outs !== '0) begin failed++; $display("FAIL midop_idle ctl got %h want 0", outs); end
        @(posedge clk);
    endtask

    task automatic test_wrap();
        build(C_B, 1, 0, 1'b0);
        run_seq(32'h17FF_FFFF, 99, 0);
        foreach (obs_q[i]) begin
            tests++;
            if (obs_q[i] !== sch[i].exp) begin failed++; $display("FAIL wrap ctl cyc%0d got %h want %h", i, obs_q[i], sch[i].exp); end
            tests++;
            if (robs[i] !== rexp[i]) begin failed++; $display("FAIL wrap instret cyc%0d got %h want %h", i, robs[i], rexp[i]); end
        end
        #1;
        tests++;
        if (instret !== 32'h0) begin failed++; $display("FAIL wrap_final instret got %h want 00000000", instret); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_stur_cbz();
        test_illegal();
        test_random();
        test_midop_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
